// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - packet-level arbiter sharing the PCIe core AXI-stream TX port among three TLP sources
//
// Purpose:
//   Grants the single s_axis_tx port to one of three TLP sources for a whole
//   packet at a time (no beat interleaving), and counts completed TLPs per
//   source for the PIO status registers. Lives in the PCIe user clock domain.
//
// Build option:
//   PCIE_TX_ARB_STRICT_CPL_EN  defined   : source 0 (completions) has absolute
//                                          priority; sources 1/2 round-robin on rr.
//                              undefined : single 3-way round-robin with a 2-bit
//                                          search pointer.
//
// Ports:
//   clock, reset       user clock, synchronous active-high reset
//   src_valid[2:0]     per-source beat valid (0 = completion, 1 = DMA write, 2 = read request)
//   src_data[191:0]    {src2, src1, src0} 64-bit beats
//   src_last[2:0]      last beat of TLP, per source
//   src_1dw[2:0]       beat carries only the low DW, per source
//   src_ready[2:0]     beat accepted, per source
//   axis_tx_*          stream towards the PCIe core (tvalid/tdata/tlast/1dw, tready)
//   grant[2:0]         one-hot owner of the TX port, 0 when idle
//   busy               a packet is in progress
//   pkt_count          {cnt2, cnt1, cnt0} completed TLPs per source, wrapping

`timescale 1ns/1ps

module pcie_tx_arbiter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 src_valid,
  input  logic [191:0]               src_data,
  input  logic [2:0]                 src_last,
  input  logic [2:0]                 src_1dw,
  output logic [2:0]                 src_ready,
  input  logic                       axis_tx_tready,
  output logic                       axis_tx_tvalid,
  output logic [63:0]                axis_tx_tdata,
  output logic                       axis_tx_tlast,
  output logic                       axis_tx_1dw,
  output logic [2:0]                 grant,
  output logic                       busy,
  output logic [3*COUNT_WIDTH-1:0]   pkt_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]             r_state;
  logic [2:0]             r_grant;
  logic [COUNT_WIDTH-1:0] r_cnt [0:2];

`ifdef PCIE_TX_ARB_STRICT_CPL_EN
  logic                   r_rr;
`else
  logic [1:0]             r_ptr;
`endif

  logic [2:0]  w_winner;
  logic        w_tvalid;
  logic [63:0] w_tdata;
  logic        w_tlast;
  logic        w_1dw;
  logic        w_pkt_done;

  // ---------------------------------------------------------------------------
  // Data path: a pure mux on the registered grant. In IDLE the grant is zero,
  // so tvalid and every src_ready bit are forced low without extra gating.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tvalid = |(r_grant & src_valid);
    w_tlast  = |(r_grant & src_last);
    w_1dw    = |(r_grant & src_1dw);
    w_tdata  = 64'd0;
    unique case (r_grant)
      3'b001:  w_tdata = src_data[63:0];
      3'b010:  w_tdata = src_data[127:64];
      3'b100:  w_tdata = src_data[191:128];
      default: w_tdata = 64'd0;
    endcase
  end

  assign axis_tx_tvalid = w_tvalid;
  assign axis_tx_tdata  = w_tdata;
  assign axis_tx_tlast  = w_tlast;
  assign axis_tx_1dw    = w_1dw;

  // src_ready depends only on tready and grant, keeping the handshake free of
  // any valid->ready combinational path.
  assign src_ready = r_grant & {3{axis_tx_tready}};

  assign w_pkt_done = w_tvalid & axis_tx_tready & w_tlast;

  // ---------------------------------------------------------------------------
  // Arbitration (only consulted in IDLE)
  // ---------------------------------------------------------------------------
`ifdef PCIE_TX_ARB_STRICT_CPL_EN
  always_comb begin
    w_winner = 3'b000;
    if (src_valid[0]) begin
      w_winner = 3'b001;
    end else if (!r_rr) begin
      if (src_valid[1])      w_winner = 3'b010;
      else if (src_valid[2]) w_winner = 3'b100;
    end else begin
      if (src_valid[2])      w_winner = 3'b100;
      else if (src_valid[1]) w_winner = 3'b010;
    end
  end
`else
  // r_ptr is the first source searched; it always holds (last owner + 1) mod 3.
  always_comb begin
    w_winner = 3'b000;
    unique case (r_ptr)
      2'd0: begin
        if (src_valid[0])      w_winner = 3'b001;
        else if (src_valid[1]) w_winner = 3'b010;
        else if (src_valid[2]) w_winner = 3'b100;
      end
      2'd1: begin
        if (src_valid[1])      w_winner = 3'b010;
        else if (src_valid[2]) w_winner = 3'b100;
        else if (src_valid[0]) w_winner = 3'b001;
      end
      2'd2: begin
        if (src_valid[2])      w_winner = 3'b100;
        else if (src_valid[0]) w_winner = 3'b001;
        else if (src_valid[1]) w_winner = 3'b010;
      end
      default: w_winner = 3'b000;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE registers the winner, OWN holds it until the tlast beat
  // transfers. A stalled owner (valid low) simply keeps the port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|src_valid) begin
            r_grant <= w_winner;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (w_pkt_done) begin
            r_grant <= 3'b000;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= 3'b000;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PCIE_TX_ARB_STRICT_CPL_EN
  // rr points at the DMA source that did not send last; completions leave it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr <= 1'b0;
    end else if (w_pkt_done) begin
      if (r_grant[1])      r_rr <= 1'b1;
      else if (r_grant[2]) r_rr <= 1'b0;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (w_pkt_done) begin
      unique case (r_grant)
        3'b001:  r_ptr <= 2'd1;
        3'b010:  r_ptr <= 2'd2;
        3'b100:  r_ptr <= 2'd0;
        default: r_ptr <= r_ptr;
      endcase
    end
  end
`endif

  // Per-source TLP counters, free-running modulo 2^COUNT_WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else if (w_pkt_done) begin
      for (int i = 0; i < 3; i++) begin
        if (r_grant[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign grant     = r_grant;
  assign busy      = |r_grant;
  assign pkt_count = {r_cnt[2], r_cnt[1], r_cnt[0]};

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb/tb_pcie_tx_arbiter.sv - self-checking bench for pcie_tx_arbiter

`timescale 1ns/1ps

module tb_pcie_tx_arbiter;

  localparam int CW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      src_valid, src_last, src_1dw, src_ready;
  logic [191:0]    src_data;
  logic            axis_tx_tready = 1'b1;
  logic            axis_tx_tvalid, axis_tx_tlast, axis_tx_1dw, busy;
  logic [63:0]     axis_tx_tdata;
  logic [2:0]      grant;
  logic [3*CW-1:0] pkt_count;

  always #5 clock = ~clock;

  pcie_tx_arbiter #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_1dw(src_1dw), .src_ready(src_ready),
    .axis_tx_tready(axis_tx_tready), .axis_tx_tvalid(axis_tx_tvalid),
    .axis_tx_tdata(axis_tx_tdata), .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_1dw(axis_tx_1dw), .grant(grant), .busy(busy), .pkt_count(pkt_count)
  );

  // Table-mode source drive
  logic         auto_mode = 1'b0;
  logic [2:0]   t_valid = '0, t_last = '0, t_1dw = '0;
  logic [191:0] t_data = {64'hC2C2_C2C2_C2C2_C2C2, 64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};

  // Packet-generating source model: data = {src id, packet no, beat no}
  int           a_len [0:2];
  int           a_npk [0:2];
  logic [2:0]   a_stall = '0;
  int           a_beat [0:2];
  int           a_pkt  [0:2];
  logic [2:0]   a_valid, a_last;
  logic [191:0] a_data;

  always_comb begin
    a_valid = '0;
    a_last  = '0;
    a_data  = '0;
    for (int s = 0; s < 3; s++) begin
      a_valid[s] = (a_pkt[s] < a_npk[s]) && !a_stall[s];
      a_last[s]  = (a_beat[s] == a_len[s] - 1);
      a_data[64*s +: 64] = {8'(s), 24'(a_pkt[s]), 32'(a_beat[s])};
    end
  end

  always @(posedge clock) begin
    for (int s = 0; s < 3; s++) begin
      if (reset) begin
        a_beat[s] <= 0;
        a_pkt[s]  <= 0;
      end else if (auto_mode && src_ready[s] && a_valid[s]) begin
        if (a_last[s]) begin
          a_beat[s] <= 0;
          a_pkt[s]  <= a_pkt[s] + 1;
        end else begin
          a_beat[s] <= a_beat[s] + 1;
        end
      end
    end
  end

  assign src_valid = auto_mode ? a_valid : t_valid;
  assign src_last  = auto_mode ? a_last  : t_last;
  assign src_1dw   = auto_mode ? 3'b000  : t_1dw;
  assign src_data  = auto_mode ? a_data  : t_data;

  // Port log (sampled on the falling edge), checked afterwards by the test
  logic [63:0] tx_data  [0:63];
  logic [2:0]  tx_grant [0:63];
  int          tn = 0;
  logic [2:0]  cy_grant [0:255];
  logic [2:0]  cy_ready [0:255];
  logic        cy_tready[0:255];
  int          cn = 0;

  always @(negedge clock) begin
    if (reset) begin
      tn <= 0;
      cn <= 0;
    end else if (auto_mode) begin
      if (cn < 256) begin
        cy_grant[cn]  <= grant;
        cy_ready[cn]  <= src_ready;
        cy_tready[cn] <= axis_tx_tready;
        cn <= cn + 1;
      end
      if (axis_tx_tvalid && axis_tx_tready && tn < 64) begin
        tx_data[tn]  <= axis_tx_tdata;
        tx_grant[tn] <= grant;
        tn <= tn + 1;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    for (int s = 0; s < 3; s++) a_npk[s] = 0;
    a_stall = '0;
    axis_tx_tready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] tdat(input int s);
    return t_data[64*s +: 64];
  endfunction

  function automatic logic [2:0] oh(input int s);
    return 3'(1 << s);
  endfunction

  typedef struct {
    logic [2:0]  v, l, d;
    logic        rdy;
    logic [2:0]  e_grant;
    logic        e_tvalid, e_tlast, e_1dw;
    logic [2:0]  e_sready;
    int          e_src;
    logic [11:0] e_cnt;
  } vec_t;

  vec_t tbl [0:9];

  initial begin
    for (int s = 0; s < 3; s++) begin
      a_len[s] = 1;
      a_npk[s] = 0;
    end

    //          valid   last    1dw     rdy   grant   tv    tl    1dw   s_ready src cnt
    tbl[0] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 0, 12'h000};
    tbl[1] = '{3'b001, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 0, 12'h000};
    tbl[2] = '{3'b001, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 3'b001, 0, 12'h000};
    tbl[3] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 0, 12'h001};
    tbl[4] = '{3'b110, 3'b110, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 0, 12'h001};
    tbl[5] = '{3'b110, 3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 3'b010, 1, 12'h001};
    tbl[6] = '{3'b100, 3'b100, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 0, 12'h011};
    tbl[7] = '{3'b100, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, 3'b000, 2, 12'h011};
    tbl[8] = '{3'b100, 3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 3'b100, 2, 12'h011};
    tbl[9] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 0, 12'h111};

    // ---- table: reset state, single completion, simultaneous DMA requests, back-pressure
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      t_valid = tbl[i].v;
      t_last  = tbl[i].l;
      t_1dw   = tbl[i].d;
      axis_tx_tready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_grant", i),  grant,          tbl[i].e_grant);
      chk($sformatf("v%0d_busy", i),   busy,           |tbl[i].e_grant);
      chk($sformatf("v%0d_tvalid", i), axis_tx_tvalid, tbl[i].e_tvalid);
      chk($sformatf("v%0d_sready", i), src_ready,      tbl[i].e_sready);
      chk($sformatf("v%0d_cnt", i),    pkt_count,      tbl[i].e_cnt);
      if (tbl[i].e_tvalid) begin
        chk($sformatf("v%0d_tlast", i), axis_tx_tlast, tbl[i].e_tlast);
        chk($sformatf("v%0d_1dw", i),   axis_tx_1dw,   tbl[i].e_1dw);
        chk($sformatf("v%0d_tdata", i), axis_tx_tdata, tdat(tbl[i].e_src));
      end
      step();
    end
    t_valid = '0;

    // ---- fair sharing: sources 1 and 2, five 4-beat packets each
    auto_mode = 1'b1;
    do_reset();
    a_len[1] = 4; a_npk[1] = 5;
    a_len[2] = 4; a_npk[2] = 5;
    for (int k = 0; k < 300; k++) begin
      if (a_pkt[1] == 5 && a_pkt[2] == 5) break;
      step();
    end
    chk("fair_done", (a_pkt[1] == 5 && a_pkt[2] == 5), 1);
    chk("fair_beats", tn, 40);
    for (int i = 0; i < 40 && i < tn; i++) begin
      chk($sformatf("fair_grant%0d", i), tx_grant[i], ((i / 4) % 2 == 0) ? 3'b010 : 3'b100);
      chk($sformatf("fair_src%0d", i),   tx_data[i][63:56], ((i / 4) % 2 == 0) ? 8'd1 : 8'd2);
      chk($sformatf("fair_beat%0d", i),  tx_data[i][31:0], 32'(i % 4));
    end
    chk("fair_cnt", pkt_count, {4'd5, 4'd5, 4'd0});

    // ---- completion arriving mid-way through a source-1 packet, source 2 pending
    do_reset();
    a_len[1] = 4; a_npk[1] = 1;
    a_len[2] = 2; a_npk[2] = 1;
    a_len[0] = 1;
    step();
    step();
    a_npk[0] = 1;
    for (int k = 0; k < 100; k++) begin
      if (a_pkt[0] == 1 && a_pkt[1] == 1 && a_pkt[2] == 1) break;
      step();
    end
    chk("prio_done", (a_pkt[0] == 1 && a_pkt[1] == 1 && a_pkt[2] == 1), 1);
    chk("prio_beats", tn, 7);
    begin
      int e_src [0:6];
      int e_bt  [0:6];
`ifdef PCIE_TX_ARB_STRICT_CPL_EN
      e_src = '{1, 1, 1, 1, 0, 2, 2};
      e_bt  = '{0, 1, 2, 3, 0, 0, 1};
`else
      e_src = '{1, 1, 1, 1, 2, 2, 0};
      e_bt  = '{0, 1, 2, 3, 0, 1, 0};
`endif
      for (int i = 0; i < 7 && i < tn; i++) begin
        chk($sformatf("prio_grant%0d", i), tx_grant[i], oh(e_src[i]));
        chk($sformatf("prio_src%0d", i),   tx_data[i][63:56], 8'(e_src[i]));
        chk($sformatf("prio_beat%0d", i),  tx_data[i][31:0], 32'(e_bt[i]));
      end
    end
    chk("prio_cnt", pkt_count, {4'd1, 4'd1, 4'd1});

    // ---- back-pressure and source stall: 8-beat source-1 packet
    do_reset();
    a_len[1] = 8; a_npk[1] = 1;
    for (int k = 0; k < 100; k++) begin
      if (a_pkt[1] == 1) break;
      axis_tx_tready = (k % 2 == 0);
      a_stall[1] = (k >= 4 && k < 7);
      step();
    end
    a_stall = '0;
    axis_tx_tready = 1'b1;
    chk("bp_done", a_pkt[1], 1);
    chk("bp_beats", tn, 8);
    for (int i = 0; i < 8 && i < tn; i++) begin
      chk($sformatf("bp_beat%0d", i), tx_data[i][31:0], 32'(i));
      chk($sformatf("bp_src%0d", i),  tx_data[i][63:56], 8'd1);
    end
    for (int i = 0; i < cn; i++) begin
      if (cy_grant[i] == 3'b010)
        chk($sformatf("bp_ready%0d", i), cy_ready[i], {1'b0, cy_tready[i], 1'b0});
    end
    chk("bp_cnt", pkt_count, {4'd0, 4'd1, 4'd0});

    // ---- reset on beat 3 of a 6-beat source-1 packet
    a_len[1] = 6; a_npk[1] = 2;
    for (int k = 0; k < 50; k++) begin
      if (a_beat[1] == 3) break;
      step();
    end
    chk("rst_reach_beat3", a_beat[1], 3);
    chk("rst_pre_busy", grant, 3'b010);
    reset = 1'b1;
    a_npk[1] = 0;
    step();
    reset = 1'b0;
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tvalid", axis_tx_tvalid, 1'b0);
    chk("rst_ready", src_ready, 3'b000);
    chk("rst_cnt", pkt_count, 12'h000);
    a_len[2] = 1; a_npk[2] = 1;
    step();
    chk("rst_new_grant", grant, 3'b100);
    chk("rst_new_tvalid", axis_tx_tvalid, 1'b1);
    step();
    chk("rst_new_idle", grant, 3'b000);
    chk("rst_new_cnt", pkt_count, {4'd1, 4'd0, 4'd0});

    // ---- counter wrap: 17 single-beat completions on a 4-bit counter
    do_reset();
    a_len[0] = 1; a_npk[0] = 17;
    for (int k = 0; k < 200; k++) begin
      if (a_pkt[0] == 17) break;
      step();
    end
    chk("wrap_done", a_pkt[0], 17);
    chk("wrap_beats", tn, 17);
    chk("wrap_cnt", pkt_count, {4'd0, 4'd0, 4'd1});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-level arbiter that shares the single AXI-stream TX port of the PCIe hard core between three TLP sources: read completions (PIO replies), DMA write TLPs (FIFO to PC), and DMA read requests (PC to FIFO). It sits between the TX-side TLP generators and the core's `s_axis_tx_*` interface, in the core's user clock domain. It grants whole packets only, never interleaving beats of different TLPs, and keeps per-source packet counters for the PIO status registers.

## Interface
Parameters:
- `COUNT_WIDTH`, default 16: width of each per-source packet counter.

Ports:
- `clock` in 1: PCIe user clock.
- `reset` in 1: synchronous, active-high reset.
- `src_valid` in 3: per-source beat valid; bit 0 = completion, bit 1 = DMA write, bit 2 = read request.
- `src_data` in 192: `{src2, src1, src0}` 64-bit beat data.
- `src_last` in 3: last beat of the TLP, per source.
- `src_1dw` in 3: beat carries only the low DW (tkeep 0x0F), per source.
- `src_ready` in 3: beat accepted, per source.
- `axis_tx_tready` in 1: core ready.
- `axis_tx_tvalid` out 1, `axis_tx_tdata` out 64, `axis_tx_tlast` out 1, `axis_tx_1dw` out 1: to the core.
- `grant` out 3: one-hot owner of the TX port; 0 when idle.
- `busy` out 1: a packet is in progress (`grant != 0`).
- `pkt_count` out 3*COUNT_WIDTH: `{cnt2, cnt1, cnt0}`, TLPs completed per source.

## Operation
- States: IDLE and OWN. The `grant` register encodes the owner.
- **IDLE:**
  - `axis_tx_tvalid` = 0 and `src_ready` = 0.
  - If any `src_valid` is high, register the winner into `grant` and go to OWN.
- **Arbitration:**
  - Completion has strict priority (see Configuration).
  - Between sources 1 and 2: round-robin on the `rr` bit. `rr` = 0 favours source 1; `rr` = 1 favours source 2.
  - `rr` toggles only when a packet from source 1 or 2 completes: `rr` becomes 1 after a source-1 packet and 0 after a source-2 packet.
- **OWN:**
  - `axis_tx_tvalid/tdata/tlast/1dw` combinationally mux the granted source.
  - `src_ready[g]` = `axis_tx_tready`; all other `src_ready` bits are 0.
- **Packet completion:**
  - A beat transfers when `axis_tx_tvalid & axis_tx_tready`.
  - On a transferred beat with `axis_tx_tlast` = 1, return to IDLE, clear `grant`, and increment `pkt_count[g]`.
- Non-granted sources hold their beat; their requests are never lost.
- Single-beat TLP (`tlast` on the first beat): one OWN cycle if `tready` is high.
- Counters wrap modulo 2^COUNT_WIDTH and have no saturation.
- The granted source deasserting `src_valid` mid-packet is legal. The arbiter stays in OWN with `tvalid` = 0 until the packet resumes. There is no timeout.

## Timing
- Reset values: `grant` = 0, `busy` = 0, `axis_tx_tvalid` = 0, `src_ready` = 0, `rr` = 0, all `pkt_count` = 0, state IDLE. `tdata/tlast/1dw` are don't-care while `tvalid` = 0.
- Latency: `src_valid` first seen in IDLE at cycle n gives `grant` at n+1 and first beat offered at n+1. A 1-cycle IDLE bubble always separates consecutive packets.
- Data path is purely combinational from `src_*` to `axis_tx_*`; only `grant`, `rr` and the counters are registered.
- Handshake is AXI-stream: `tvalid` does not depend on `tready`, and `src_ready` depends on `tready` and `grant` only.
- `reset` asserted mid-packet abandons the packet immediately, and the outputs take their reset values on the next edge. Sources are reset by the same signal.
- Simultaneous requests in IDLE resolve in one cycle per the priority rules.

## Configuration
- `PCIE_TX_ARB_STRICT_CPL_EN` defined: completion (source 0) has absolute priority over sources 1 and 2, so PIO reads are never starved by DMA.
- `PCIE_TX_ARB_STRICT_CPL_EN` undefined:
  - All three sources take part in one round-robin, with a 2-bit pointer replacing `rr`.
  - Search order starts at (last granted + 1) mod 3; the pointer resets to source 0 so that source 0 is searched first after reset.
  - The pointer updates on every packet completion.

## Test plan
- **Single completion:** single-beat completion, `tready` = 1.
  - `grant` = 001 one cycle after `src_valid[0]`.
  - One beat out with `tlast` = 1 and `1dw` passed through.
  - `pkt_count[0]` = 1.
  - Back to IDLE next cycle.
- **Fair sharing:** sources 1 and 2 both continuously send 4-beat packets.
  - Grants alternate 010, 100, 010, ...
  - After 10 packets, `cnt1` = `cnt2` = 5.
  - No beat interleaving within a packet.
- **Strict completion priority, macro defined:** a completion arrives mid-way through a source-1 packet.
  - The completion waits for the source-1 `tlast`.
  - It is then granted ahead of a pending source 2.
- **Back-pressure and source stall:** `tready` toggles 1,0,1,0 during an 8-beat source-1 packet, and source 1 drops `src_valid` for 3 cycles.
  - All 8 beats arrive in order with no duplicates.
  - `src_ready[1]` tracks `tready`.
- **Reset mid-packet:** `reset` on beat 3 of 6.
  - Next cycle: `grant` = 0, `tvalid` = 0, counters = 0.
  - A new request after reset is granted normally.
- **Counter wrap:** `COUNT_WIDTH` = 4, 17 completions.
  - `cnt0` = 1.
